// File: rtl/iiitb_bc_decoder.sv
// Receive-side monitor for the 4-bit up/down counter: recovers direction, net position,
// wrap and illegal-jump events. Optional `IIITB_BC_WRAP_CNT_EN enables the wrap counter.
module iiitb_bc_decoder #(
    parameter int POS_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sample_valid,
    input  logic [3:0]       count_in,
    input  logic             clear_err,
    output logic             dir_valid,
    output logic             dir_up,
    output logic             dir_change,
    output logic             wrap_pulse,
    output logic             err_pulse,
    output logic             fault,
    output logic [POS_W-1:0] pos_count,
    output logic [7:0]       err_count,
    output logic [7:0]       wrap_count
);

    typedef enum logic [2:0] {IDLE, SYNC, UP, DOWN, FAULT} state_t;

    state_t     state, nxt;
    logic [3:0] prev;
    logic [3:0] delta;
    logic       accept, ev_up, ev_dn, ev_err, ev_wrap, ev_chg;

    always_comb begin
        delta   = count_in - prev;
        nxt     = state;
        accept  = 1'b0;
        ev_up   = 1'b0;
        ev_dn   = 1'b0;
        ev_err  = 1'b0;
        ev_wrap = 1'b0;
        ev_chg  = 1'b0;
        case (state)
            IDLE: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    nxt    = SYNC;
                end
            end
            SYNC, UP, DOWN: begin
                if (sample_valid) begin
                    accept = 1'b1;
                    if (delta == 4'd1) begin
                        ev_up   = 1'b1;
                        ev_wrap = (prev == 4'd15);
                        ev_chg  = (state == DOWN);
                        nxt     = UP;
                    end else if (delta == 4'd15) begin
                        ev_dn   = 1'b1;
                        ev_wrap = (prev == 4'd0);
                        ev_chg  = (state == UP);
                        nxt     = DOWN;
                    end else if (delta != 4'd0) begin
                        // Illegal jumps before lock are counted but do not fault.
                        ev_err = 1'b1;
                        if (state != SYNC)
                            nxt = FAULT;
                    end
                end
            end
            FAULT: begin
                if (clear_err)
                    nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            prev       <= '0;
            dir_valid  <= 1'b0;
            dir_up     <= 1'b0;
            dir_change <= 1'b0;
            wrap_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            fault      <= 1'b0;
            pos_count  <= '0;
            err_count  <= '0;
        end else begin
            state      <= nxt;
            if (accept)
                prev <= count_in;
            dir_valid  <= (nxt == UP) || (nxt == DOWN);
            dir_up     <= (nxt == UP);
            fault      <= (nxt == FAULT);
            dir_change <= ev_chg;
            wrap_pulse <= ev_wrap;
            err_pulse  <= ev_err;
            if (ev_up)
                pos_count <= pos_count + POS_W'(1);
            else if (ev_dn)
                pos_count <= pos_count - POS_W'(1);
            if (ev_err && (err_count != 8'hFF))
                err_count <= err_count + 8'd1;
        end
    end

`ifdef IIITB_BC_WRAP_CNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            wrap_count <= '0;
        else if (ev_wrap && (wrap_count != 8'hFF))
            wrap_count <= wrap_count + 8'd1;
    end
`else
    assign wrap_count = '0;
`endif

endmodule

// File: tb/tb_iiitb_bc_decoder.sv
// Self-checking bench for iiitb_bc_decoder: directed vector table, saturation runs,
// and randomized traffic against a behavioural model.
module tb_iiitb_bc_decoder;

    localparam int POS_W = 16;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             sample_valid = 1'b0;
    logic [3:0]       count_in = '0;
    logic             clear_err = 1'b0;
    logic             dir_valid, dir_up, dir_change, wrap_pulse, err_pulse, fault;
    logic [POS_W-1:0] pos_count;
    logic [7:0]       err_count, wrap_count;

    int checks = 0;
    int failures = 0;

    iiitb_bc_decoder #(.POS_W(POS_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .count_in     (count_in),
        .clear_err    (clear_err),
        .dir_valid    (dir_valid),
        .dir_up       (dir_up),
        .dir_change   (dir_change),
        .wrap_pulse   (wrap_pulse),
        .err_pulse    (err_pulse),
        .fault        (fault),
        .pos_count    (pos_count),
        .err_count    (err_count),
        .wrap_count   (wrap_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: 0 idle, 1 sync, 2 up, 3 down, 4 fault
    int m_mode = 0;
    int m_prev = 0;
    int m_pos  = 0;
    int m_ec   = 0;
    int m_wc   = 0;
    int m_chg  = 0;
    int m_wrap = 0;
    int m_err  = 0;

    task automatic model_step(input bit r, input bit v, input int c, input bit clr);
        int d;
        m_chg = 0; m_wrap = 0; m_err = 0;
        if (r) begin
            m_mode = 0; m_prev = 0; m_pos = 0; m_ec = 0; m_wc = 0;
        end else if (m_mode == 4) begin
            if (clr) m_mode = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                m_mode = 1;
            end else begin
                d = (c - m_prev + 16) % 16;
                if (d == 1 || d == 15) begin
                    if ((d == 1 && m_prev == 15) || (d == 15 && m_prev == 0)) begin
                        m_wrap = 1;
                        if (m_wc < 255) m_wc++;
                    end
                    if ((d == 1 && m_mode == 3) || (d == 15 && m_mode == 2)) m_chg = 1;
                    m_pos  = m_pos + ((d == 1) ? 1 : -1);
                    m_mode = (d == 1) ? 2 : 3;
                end else if (d != 0) begin
                    m_err = 1;
                    if (m_ec < 255) m_ec++;
                    if (m_mode != 1) m_mode = 4;
                end
            end
            m_prev = c;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit r, input bit v, input int c, input bit clr);
        reset        = r;
        sample_valid = v;
        count_in     = 4'(c);
        clear_err    = clr;
        @(posedge clk);
        model_step(r, v, c, clr);
        #1;
    endtask

    task automatic check_model(input string tag);
        int exp_wc;
`ifdef IIITB_BC_WRAP_CNT_EN
        exp_wc = m_wc;
`else
        exp_wc = 0;
`endif
        chk({tag, ".dir_valid"}, dir_valid, (m_mode == 2 || m_mode == 3) ? 1 : 0);
        if (m_mode == 2 || m_mode == 3)
            chk({tag, ".dir_up"}, dir_up, (m_mode == 2) ? 1 : 0);
        chk({tag, ".fault"}, fault, (m_mode == 4) ? 1 : 0);
        chk({tag, ".dir_change"}, dir_change, m_chg);
        chk({tag, ".wrap_pulse"}, wrap_pulse, m_wrap);
        chk({tag, ".err_pulse"}, err_pulse, m_err);
        chk({tag, ".pos_count"}, pos_count, m_pos & 32'hFFFF);
        chk({tag, ".err_count"}, err_count, m_ec);
        chk({tag, ".wrap_count"}, wrap_count, exp_wc);
    endtask

    typedef struct {
        bit r, v;
        int c;
        bit clr;
        bit dv, du, fl;
        bit chg, wrp, err;
        int pos;
        int ec;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit r, bit v, int c, bit clr, bit dv, bit du, bit fl,
                                bit chg, bit wrp, bit err, int pos, int ec);
        vec_t x;
        x.r = r; x.v = v; x.c = c; x.clr = clr; x.dv = dv; x.du = du; x.fl = fl;
        x.chg = chg; x.wrp = wrp; x.err = err; x.pos = pos; x.ec = ec;
        return x;
    endfunction

    initial begin
        //                r  v  c  clr dv du fl chg wrp err pos  ec
        // up lock
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 3, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 1, 1, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 1, 5, 0, 1, 1, 0, 0, 0, 0,  2, 0));
        // up wrap
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 14,0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 15,0, 1, 1, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 1, 0, 0, 1, 0,  2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0,  2, 0));
        // direction change, then reset mid-run while DOWN at -3 with valid held
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 6, 0, 1, 1, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 1, 5, 0, 1, 0, 0, 1, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 1, 0, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(0, 1, 3, 0, 1, 0, 0, 0, 0, 0, -2, 0));
        tbl.push_back(mk(0, 1, 2, 0, 1, 0, 0, 0, 0, 0, -3, 0));
        tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0, -1, 0));
        tbl.push_back(mk(0, 1, 15,0, 1, 0, 0, 0, 1, 0, -2, 0));
        // SYNC error
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 2, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 7, 0, 0, 0, 0, 0, 0, 1,  0, 1));
        tbl.push_back(mk(0, 1, 8, 0, 1, 1, 0, 0, 0, 0,  1, 1));
        // fault, ignored samples, clear (sample in clear cycle ignored), re-acquire
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 4, 0, 0, 0, 0, 0, 0, 0,  0, 0));
        tbl.push_back(mk(0, 1, 5, 0, 1, 1, 0, 0, 0, 0,  1, 0));
        tbl.push_back(mk(0, 1, 6, 0, 1, 1, 0, 0, 0, 0,  2, 0));
        tbl.push_back(mk(0, 1, 9, 0, 0, 0, 1, 0, 0, 1,  2, 1));
        tbl.push_back(mk(0, 1, 10,0, 0, 0, 1, 0, 0, 0,  2, 1));
        tbl.push_back(mk(0, 1, 0, 1, 0, 0, 0, 0, 0, 0,  2, 1));
        tbl.push_back(mk(0, 1, 7, 1, 0, 0, 0, 0, 0, 0,  2, 1));
        tbl.push_back(mk(0, 1, 8, 0, 1, 1, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(0, 1, 8, 0, 1, 1, 0, 0, 0, 0,  3, 1));
        tbl.push_back(mk(0, 0, 3, 0, 1, 1, 0, 0, 0, 0,  3, 1));

        foreach (tbl[i]) begin
            apply(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].clr);
            chk($sformatf("vec%0d.dir_valid", i), dir_valid, tbl[i].dv);
            if (tbl[i].dv)
                chk($sformatf("vec%0d.dir_up", i), dir_up, tbl[i].du);
            chk($sformatf("vec%0d.fault", i), fault, tbl[i].fl);
            chk($sformatf("vec%0d.dir_change", i), dir_change, tbl[i].chg);
            chk($sformatf("vec%0d.wrap_pulse", i), wrap_pulse, tbl[i].wrp);
            chk($sformatf("vec%0d.err_pulse", i), err_pulse, tbl[i].err);
            chk($sformatf("vec%0d.pos_count", i), pos_count, tbl[i].pos & 32'hFFFF);
            chk($sformatf("vec%0d.err_count", i), err_count, tbl[i].ec);
            if (tbl[i].r)
                chk($sformatf("vec%0d.wrap_count", i), wrap_count, 0);
        end

        // err_count saturation: repeated illegal jumps in SYNC never fault
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        for (int i = 0; i < 260; i++) begin
            apply(0, 1, (i % 2 == 0) ? 8 : 0, 0);
            check_model("errsat");
        end
        chk("errsat.final", err_count, 255);
        apply(0, 1, 1, 0);
        apply(0, 1, 2, 0);
        chk("errsat.hold", err_count, 255);

        // wrap_count saturation: many full up-laps
        apply(1, 0, 0, 0);
        apply(0, 1, 0, 0);
        for (int i = 1; i <= 16 * 270; i++) begin
            apply(0, 1, i % 16, 0);
            if (i % 16 == 0 || i > 16 * 268) check_model("wrapsat");
        end

        // randomized traffic against the model
        apply(1, 0, 0, 0);
        for (int i = 0; i < 4000; i++) begin
            int  sel, c;
            bit  r, v, clr;
            logic [3:0] p;
            p   = 4'(m_prev);
            sel = $urandom_range(0, 9);
            if (sel <= 2)      c = int'(4'(p + 4'd1));
            else if (sel <= 5) c = int'(4'(p - 4'd1));
            else if (sel <= 7) c = int'(p);
            else               c = $urandom_range(0, 15);
            v   = ($urandom_range(0, 9) < 8);
            clr = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 199) == 0);
            apply(r, v, c, clr);
            check_model("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iiitb_bc_decoder.md
# iiitb_bc_decoder

Receive-side monitor for the 4-bit up/down counter's `Count` bus. It samples the count stream, recovers the counting direction, and tracks net position and wrap events. It flags any illegal jump between consecutive samples. It sits downstream of the counter, on the consumer side of the count interface, and feeds status and debug logic.

## Interface
Parameters:
- `POS_W`, default 16: width of the net position accumulator.

Ports (clock and reset first):
- `clk`  in  1  sampling clock.
- `reset`  in  1  reset; synchronous, active-high.
- `sample_valid`  in  1  `count_in` holds a new sample this cycle.
- `count_in`  in  4  counter value being observed.
- `clear_err`  in  1  one-cycle request to leave FAULT.
- `dir_valid`  out  1  direction is known (state UP or DOWN).
- `dir_up`  out  1  1 = counting up, 0 = counting down; meaningful only when `dir_valid` is high.
- `dir_change`  out  1  one-cycle pulse on an UP↔DOWN transition.
- `wrap_pulse`  out  1  one-cycle pulse on an accepted step 15→0 or 0→15.
- `err_pulse`  out  1  one-cycle pulse on any illegal delta.
- `fault`  out  1  high while in FAULT.
- `pos_count`  out  `POS_W`  two's-complement net steps.
- `err_count`  out  8  saturating error count.
- `wrap_count`  out  8  saturating wrap count (see Configuration).

## Operation
- Reset values: all outputs 0, state IDLE, stored previous sample `prev` = 0.
- Delta computation: delta = (`count_in` − `prev`) mod 16, computed on 4 bits.
  - 1 = up step.
  - 15 = down step.
  - 0 = hold.
  - Any other value = illegal.
- Every accepted sample updates `prev`. In FAULT, samples are not accepted and `prev` is not updated.
- States:
  - IDLE: on a valid sample, latch `prev` and go to SYNC. No delta check is made.
  - SYNC:
    - up step → UP.
    - down step → DOWN.
    - hold → stay in SYNC.
    - illegal → stay in SYNC, `err_pulse`, `err_count` +1. No fault is raised.
  - UP / DOWN:
    - up step → UP.
    - down step → DOWN.
    - hold → stay.
    - Moving from UP to DOWN or DOWN to UP pulses `dir_change`.
    - illegal → FAULT, `err_pulse`, `err_count` +1.
  - FAULT: `sample_valid` is ignored. `clear_err` → IDLE.
- Position tracking: every accepted up step adds 1 to `pos_count`, every down step subtracts 1, wrapping mod 2^`POS_W`. Hold and illegal samples leave it unchanged.
- Wrap detection: `wrap_pulse` fires for an up step with `prev`=15 or a down step with `prev`=0. This applies in SYNC, UP and DOWN.
- `err_count` saturates at 255 and is cleared only by `reset`. `clear_err` does not clear it.
- `clear_err` outside FAULT has no effect.
- Priority:
  - `reset` overrides everything.
  - In FAULT, `clear_err` is the only input acted on.

## Timing
- All outputs are registered. A sample presented at edge N is reflected on all outputs after edge N (latency 1 cycle).
- Pulses (`dir_change`, `wrap_pulse`, `err_pulse`) are high for exactly one cycle per event.
- Back-to-back valid samples are accepted every cycle; there is no backpressure.
- `fault` rises in the cycle after the illegal sample. It falls in the cycle after `clear_err` is sampled; `dir_valid` is 0 at that point.
- Reset mid-operation: after the reset edge, state returns to IDLE and every output is at its reset value. The next valid sample only re-acquires (IDLE → SYNC); no delta check is made on it.

## Configuration
- `IIITB_BC_WRAP_CNT_EN` defined: `wrap_count` increments on each `wrap_pulse`, saturates at 255, and is cleared only by `reset`.
- Not defined: `wrap_count` is tied to 0 and the counter logic is absent. `wrap_pulse` is unaffected.

## Test plan
- Up lock: reset, then samples 3, 4, 5 → after the last sample, `dir_valid`=1, `dir_up`=1, `pos_count`=2, `err_count`=0.
- Up wrap: after lock, samples 14, 15, 0 → `wrap_pulse` one cycle after sample 0. With the macro defined, `wrap_count`=1.
- Direction change: samples 5, 6, 5 → `dir_change` pulse, `dir_up`=0, `pos_count`=0. Then 0, 15 gives `wrap_pulse` on the 0→15 step.
- SYNC error: reset, samples 2, 7, 8 → `err_pulse` after 7 with `err_count`=1 and `fault`=0. After 8, `dir_up`=1.
- Fault: locked UP at 6, then sample 9 → `fault`=1, `err_count` increments. Further samples leave `pos_count` unchanged. `clear_err` → `fault`=0, `dir_valid`=0, and the next sample re-acquires without error.
- Reset mid-run: assert `reset` while in DOWN with `pos_count`=−3 → all outputs are 0 next cycle. `sample_valid` held with `reset` is ignored.
